uart_tx_io: RTL

//  Memory-mapped UART transmitter on the maxicore32 external bus, downstream of the core's address/data/strobe outputs.
//  CPU writes bytes into a TX FIFO; an 8N1 serialiser drains it at a programmable bit rate.
//  The external address decoder drives cs; the block returns registered read data for OR-ing onto the bus.

---
 rtl/uart_tx_io.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_io.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_io
// Purpose  : Memory-mapped 8N1 UART transmitter for the maxicore32 external
//            bus. The CPU pushes bytes into a circular TX FIFO, and a
//            serialiser drains it at a programmable bit rate.
//            Read data is registered and is zero whenever it is not returning
//            a read, so it can be OR-ed onto the bus.
// Config   : define UART_TX_IRQ_EN to add the irq port and IRQCTL register.
// Ports    : clock, reset        - rising-edge clock, synchronous active-high
//            cs, address[1:0]    - decoder select, word offset
//            data_in[31:0]       - write data
//            data_strobes[3:0]   - byte lane enables
//            read, write         - bus cycle type (write wins if both high)
//            data_out[31:0]      - registered read data
//            tx                  - serial line, idle high
//            irq                 - level interrupt (UART_TX_IRQ_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_io #(
    parameter int                       FIFO_DEPTH_LOG2 = 4,
    parameter int                       DIVISOR_WIDTH   = 16,
    parameter logic [DIVISOR_WIDTH-1:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  data_strobes,
    input  logic        read,
    input  logic        write,
    output logic [31:0] data_out,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int                   c_DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] c_ADDR_DATA    = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] c_ADDR_DIVISOR = 2'd2;
    localparam logic [1:0] c_ADDR_IRQCTL  = 2'd3;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]                 r_mem [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       r_overflow;
    logic [DIVISOR_WIDTH-1:0]   r_divisor;
    logic [31:0]                r_data_out;

    logic [1:0]                 r_state;
    logic [DIVISOR_WIDTH-1:0]   r_timer;
    logic [2:0]                 r_index;
    logic [7:0]                 r_shift;
    logic                       r_tx;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_wr_en;
    logic w_rd_en;
    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_busy;
    logic w_ovf_set;
    logic w_ovf_clr;
    logic [DIVISOR_WIDTH-1:0] w_reload;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;
    logic        w_unused_data;

    // A cycle with both read and write high is treated as a write only.
    assign w_wr_en    = cs && write;
    assign w_rd_en    = cs && read && !write;
    assign w_push_req = w_wr_en && (address == c_ADDR_DATA) && (data_strobes == 4'b1111);

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != c_ST_IDLE);

    // The serialiser takes a byte whenever it sits idle with data queued.
    assign w_pop = (r_state == c_ST_IDLE) && !w_empty;

    // A push into a full FIFO still fits if a pop frees the slot this cycle;
    // the write then lands on the slot being read, which is safe because the
    // pop reads the pre-edge contents.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop;
    assign w_ovf_clr = w_rd_en && (address == c_ADDR_STATUS);

    // Divisor 0 behaves as 1: a bit lasts timer reload + 1 clocks.
    assign w_reload = (r_divisor == '0) ? '0 : r_divisor - DIVISOR_WIDTH'(1);

    assign w_unused_data = ^data_in;

    always_comb begin
        w_status                          = '0;
        w_status[0]                       = w_busy;
        w_status[1]                       = w_full;
        w_status[2]                       = w_empty;
        w_status[3]                       = r_overflow;
        w_status[8 +: FIFO_DEPTH_LOG2+1]  = r_count;
    end

`ifdef UART_TX_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && (address == c_ADDR_IRQCTL)) begin
                r_irq_en <= data_in[1:0];
            end
            r_irq <= (r_irq_en[0] && w_empty && !w_busy) || (r_irq_en[1] && r_overflow);
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_rd_data = '0;
        case (address)
            c_ADDR_STATUS:  w_rd_data = w_status;
            c_ADDR_DIVISOR: w_rd_data[DIVISOR_WIDTH-1:0] = r_divisor;
`ifdef UART_TX_IRQ_EN
            c_ADDR_IRQCTL:  w_rd_data[1:0] = r_irq_en;
`endif
            default:        w_rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus registers, FIFO pointers and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_divisor  <= DEFAULT_DIVISOR;
        end else begin
            r_data_out <= w_rd_en ? w_rd_data : 32'd0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            // A new overflow in the same cycle as the clearing read survives.
            r_overflow <= (r_overflow && !w_ovf_clr) || w_ovf_set;

            if (w_wr_en && (address == c_ADDR_DIVISOR)) begin
                r_divisor <= data_in[DIVISOR_WIDTH-1:0];
            end
        end
    end

    // FIFO storage needs no reset; the count guards stale entries.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: the bit timer is reloaded from the divisor at every bit
    // boundary, so a divisor write only affects the following bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_timer <= '0;
            r_index <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_timer <= w_reload;
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (r_timer == '0) begin
                        r_timer <= w_reload;
                        r_index <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= c_ST_DATA;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (r_timer == '0) begin
                        r_timer <= w_reload;
                        if (r_index == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                c_ST_STOP: begin
                    r_tx <= 1'b1;
                    if (r_timer == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign tx       = r_tx;

endmodule
`default_nettype wire
